// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pkg
//  Brief    : Shared encodings for the Pong match controller and ball engine.
//  Revision : 1.0  initial release
// ============================================================================
package pong_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_DONE  = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        BALL_PLAYING = 2'b00,
        BALL_P1WIN   = 2'b01,
        BALL_P2WIN   = 2'b10,
        BALL_RSVD    = 2'b11
    } ball_status_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    // Ball recentre point used by the ball engine at every serve
    localparam logic [9:0] c_ball_x0 = 10'd304;
    localparam logic [9:0] c_ball_y0 = 10'd224;

endpackage
`default_nettype wire

// File: rtl/pong_delay_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pong_delay_cnt
//  Brief    : Clearable/enabled delay counter with terminal-count compare.
//  Revision : 1.0  initial release
// ============================================================================
module pong_delay_cnt #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign at_term = (r_count == term);

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pong_game_ctrl
//  Brief    : Pong match controller: serve timing, scoring, winner detection.
//             Optional macro PONG_AUTO_RESTART_EN returns DONE to START on a
//             timeout as well as on start_btn.
//  Revision : 1.0  initial release
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_CYCLES = 25000000,
    parameter int CNT_W        = 25,
    parameter int DONE_CYCLES  = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic [1:0] ball_status,
    output logic [1:0] state,
    output logic       serve,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner
);

    localparam logic [CNT_W-1:0] c_serve_term = CNT_W'(SERVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_done_term  = CNT_W'(DONE_CYCLES - 1);
    localparam logic [3:0]       c_win        = 4'(WIN_SCORE);

    game_state_t      r_state, w_state_nxt;
    winner_t          r_winner, w_winner_nxt;
    logic             r_serve, w_serve_nxt;
    logic [3:0]       r_score1, w_score1_nxt, w_score1_inc;
    logic [3:0]       r_score2, w_score2_nxt, w_score2_inc;
    logic             w_cnt_clr, w_cnt_en, w_at_term;
    logic [CNT_W-1:0] w_cnt_term;

    assign w_score1_inc = r_score1 + 4'd1;
    assign w_score2_inc = r_score2 + 4'd1;
    assign w_cnt_term   = (r_state == ST_DONE) ? c_done_term : c_serve_term;

    pong_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_cnt_clr),
        .en      (w_cnt_en),
        .term    (w_cnt_term),
        .at_term (w_at_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_START;
            r_serve  <= 1'b0;
            r_score1 <= 4'd0;
            r_score2 <= 4'd0;
            r_winner <= WIN_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_serve  <= w_serve_nxt;
            r_score1 <= w_score1_nxt;
            r_score2 <= w_score2_nxt;
            r_winner <= w_winner_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_serve_nxt  = r_serve;
        w_score1_nxt = r_score1;
        w_score2_nxt = r_score2;
        w_winner_nxt = r_winner;
        w_cnt_en     = 1'b0;
        w_cnt_clr    = 1'b1;
        case (r_state)
            ST_START: begin
                w_score1_nxt = 4'd0;
                w_score2_nxt = 4'd0;
                w_winner_nxt = WIN_NONE;
                if (start_btn) begin
                    w_state_nxt = ST_SERVE;
                    w_serve_nxt = 1'b0;
                end
            end
            ST_SERVE: begin
                w_cnt_en  = 1'b1;
                w_cnt_clr = w_at_term;
                if (w_at_term) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Leaving PLAY on the scoring cycle guarantees one point per rally
                if (ball_status == BALL_P1WIN) begin
                    w_score1_nxt = w_score1_inc;
                    w_serve_nxt  = 1'b1;
                    if (w_score1_inc == c_win) begin
                        w_state_nxt  = ST_DONE;
                        w_winner_nxt = WIN_P1;
                    end else begin
                        w_state_nxt  = ST_SERVE;
                    end
                end else if (ball_status == BALL_P2WIN) begin
                    w_score2_nxt = w_score2_inc;
                    w_serve_nxt  = 1'b0;
                    if (w_score2_inc == c_win) begin
                        w_state_nxt  = ST_DONE;
                        w_winner_nxt = WIN_P2;
                    end else begin
                        w_state_nxt  = ST_SERVE;
                    end
                end
            end
            ST_DONE: begin
`ifdef PONG_AUTO_RESTART_EN
                w_cnt_en  = 1'b1;
                w_cnt_clr = start_btn | w_at_term;
                if (start_btn || w_at_term) begin
`else
                if (start_btn) begin
`endif
                    w_state_nxt  = ST_START;
                    w_score1_nxt = 4'd0;
                    w_score2_nxt = 4'd0;
                    w_winner_nxt = WIN_NONE;
                end
            end
            default: begin
                w_state_nxt = ST_START;
            end
        endcase
    end

    assign state  = r_state;
    assign serve  = r_serve;
    assign score1 = r_score1;
    assign score2 = r_score2;
    assign winner = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_game_ctrl
//  Brief    : Self-checking bench for pong_game_ctrl against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int WIN   = 2;
    localparam int SERVE = 4;
    localparam int DONEC = 6;

    logic       clk;
    logic       rst_n;
    logic       start_btn;
    logic [1:0] ball_status;
    logic [1:0] state;
    logic       serve;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;

    pong_game_ctrl #(
        .WIN_SCORE    (WIN),
        .SERVE_CYCLES (SERVE),
        .CNT_W        (4),
        .DONE_CYCLES  (DONEC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_btn   (start_btn),
        .ball_status (ball_status),
        .state       (state),
        .serve       (serve),
        .score1      (score1),
        .score2      (score2),
        .winner      (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    // Model: mode 0 START, 1 SERVE, 2 PLAY, 3 DONE; m_t counts cycles spent in mode
    int   m_mode, m_t, m_s1, m_s2, m_win;
    logic m_srv;

    wire [15:0] dut_vec = {3'b000, state, serve, score1, score2, winner};

    function automatic logic [15:0] mk(input int md, input logic sv, input int a,
                                       input int b, input int w);
        return {3'b000, 2'(md), sv, 4'(a), 4'(b), 2'(w)};
    endfunction

    function automatic logic [15:0] model_vec();
        return mk(m_mode, m_srv, m_s1, m_s2, m_win);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_srv = 1'b0;
    endtask

    task automatic model_to_start();
        m_mode = 0; m_t = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
    endtask

    task automatic model_step(input logic st, input logic [1:0] bs);
        case (m_mode)
            0: if (st) begin m_mode = 1; m_srv = 1'b0; m_t = 0; end
            1: begin
                m_t++;
                if (m_t == SERVE) begin m_t = 0; m_mode = 2; end
            end
            2: begin
                if (bs == 2'b01) begin
                    m_s1++; m_srv = 1'b1;
                    if (m_s1 == WIN) begin m_mode = 3; m_win = 1; end else m_mode = 1;
                end else if (bs == 2'b10) begin
                    m_s2++; m_srv = 1'b0;
                    if (m_s2 == WIN) begin m_mode = 3; m_win = 2; end else m_mode = 1;
                end
            end
            default: begin
`ifdef PONG_AUTO_RESTART_EN
                m_t++;
                if (st || m_t == DONEC) model_to_start();
`else
                if (st) model_to_start();
`endif
            end
        endcase
    endtask

    // Called at posedge+1; leaves the bench at the next posedge+1
    task automatic cycle(input logic st, input logic [1:0] bs);
        start_btn   = st;
        ball_status = bs;
        @(posedge clk);
        model_step(st, bs);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n       = 1'b0;
        start_btn   = 1'b0;
        ball_status = 2'b00;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_on) check("cycle", dut_vec, model_vec());
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st;
        logic [1:0] bs;
        int r;
        rst_n = 1'b0; start_btn = 1'b0; ball_status = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_values", dut_vec, 16'h0000);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Start at cycle 5: SERVE next, PLAY four cycles later
        repeat (4) cycle(1'b0, 2'b00);
        cycle(1'b1, 2'b00);
        check("start_to_serve", dut_vec, mk(1, 1'b0, 0, 0, 0));
        repeat (3) cycle(1'b0, 2'b00);
        check("serve_hold", dut_vec, mk(1, 1'b0, 0, 0, 0));
        cycle(1'b0, 2'b00);
        check("serve_to_play", dut_vec, mk(2, 1'b0, 0, 0, 0));

        // Player 1 point held two cycles counts once
        cycle(1'b0, 2'b01);
        check("p1_point", dut_vec, mk(1, 1'b1, 1, 0, 0));
        cycle(1'b0, 2'b01);
        check("p1_point_once", dut_vec, mk(1, 1'b1, 1, 0, 0));
        repeat (2) cycle(1'b0, 2'b00);
        check("reserve_hold", dut_vec, mk(1, 1'b1, 1, 0, 0));
        cycle(1'b0, 2'b00);
        check("reserve_play", dut_vec, mk(2, 1'b1, 1, 0, 0));

        // Reserved status and start_btn do nothing in PLAY
        repeat (10) cycle(1'b0, 2'b11);
        cycle(1'b1, 2'b00);
        check("reserved_status", dut_vec, mk(2, 1'b1, 1, 0, 0));

        // Two player 2 points -> match over
        cycle(1'b0, 2'b10);
        check("p2_point", dut_vec, mk(1, 1'b0, 1, 1, 0));
        repeat (4) cycle(1'b0, 2'b00);
        cycle(1'b0, 2'b10);
        check("p2_wins", dut_vec, mk(3, 1'b0, 1, 2, 2));
        cycle(1'b0, 2'b01);
        cycle(1'b0, 2'b10);
        cycle(1'b0, 2'b11);
        cycle(1'b0, 2'b01);
        check("done_frozen", dut_vec, mk(3, 1'b0, 1, 2, 2));
`ifdef PONG_AUTO_RESTART_EN
        cycle(1'b0, 2'b00);
        check("auto_pre", dut_vec, mk(3, 1'b0, 1, 2, 2));
        cycle(1'b0, 2'b00);
        check("auto_restart", dut_vec, mk(0, 1'b0, 0, 0, 0));
`else
        repeat (4) cycle(1'b0, 2'b00);
        check("done_stays", dut_vec, mk(3, 1'b0, 1, 2, 2));
        cycle(1'b1, 2'b00);
        check("done_to_start", dut_vec, mk(0, 1'b0, 0, 0, 0));
`endif

        // Reach 1/1 in SERVE, then assert reset between clock edges
        cycle(1'b1, 2'b00);
        repeat (4) cycle(1'b0, 2'b00);
        cycle(1'b0, 2'b01);
        repeat (4) cycle(1'b0, 2'b00);
        cycle(1'b0, 2'b10);
        cycle(1'b0, 2'b00);
        check("pre_async", dut_vec, mk(1, 1'b0, 1, 1, 0));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", dut_vec, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised play against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                st = ($urandom_range(0, 14) == 0);
                r  = $urandom_range(0, 9);
                bs = (r < 6) ? 2'b00 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 :
                     (r == 8) ? 2'b11 : 2'($urandom_range(0, 3));
                cycle(st, bs);
            end
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
